// File: rtl/decode_cs_if.sv
// Decode-to-ControlStore bundle: fetch handshake, ROM address/data, and the AGEX-side latch.
// Latency: none, wiring only.
// Backpressure: carries in_ready/out_ready; the slave side owns the stall decisions.
interface decode_cs_if #(
    parameter int CS_W   = 23,
    parameter int ADDR_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_ir;
    logic [15:0]       in_npc;
    logic              flush;
    logic [ADDR_W-1:0] cs_addr;
    logic [CS_W-1:0]   cs_bits;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_ir;
    logic [15:0]       out_npc;
    logic [CS_W-1:0]   out_cs;

    // Environment side: fetch, ROM and AGEX.
    modport master (
        output in_valid, in_ir, in_npc, flush, cs_bits, out_ready,
        input  in_ready, cs_addr, out_valid, out_ir, out_npc, out_cs
    );

    // Decode stage side.
    modport slave (
        input  in_valid, in_ir, in_npc, flush, cs_bits, out_ready,
        output in_ready, cs_addr, out_valid, out_ir, out_npc, out_cs
    );
endinterface

// File: rtl/decode_cs_stage.sv
// Decode front end: drives the ControlStore address, pairs the ROM's registered word with its instruction.
// Latency: 2 cycles from accept to out_valid; sustains 1 instruction/cycle.
// Backpressure: out_ready low holds B then A (A's address is replayed); in_ready drops when both are full.
module decode_cs_stage #(
    parameter int CS_W   = 23,
    parameter int ADDR_W = 6
) (
    input  logic       clk,
    input  logic       reset,
    decode_cs_if.slave bus
);
    // Slot A: address has gone to the ROM; its word arrives on cs_bits next cycle.
    logic            a_valid;
    logic [15:0]     a_ir;
    logic [15:0]     a_npc;
    // Slot B: instruction and its captured control word, presented to AGEX.
    logic            b_valid;
    logic [15:0]     b_ir;
    logic [15:0]     b_npc;
    logic [CS_W-1:0] b_cs;

    logic b_free;
    logic a_adv;
    logic load_a;

    function automatic logic [ADDR_W-1:0] caddr(input logic [15:0] ir);
        return ADDR_W'({ir[15:12], ir[11], ir[5]});
    endfunction

    assign b_free       = !b_valid || bus.out_ready;
    assign a_adv        = a_valid && b_free && !bus.flush;
    assign bus.in_ready = !reset && !bus.flush && (!a_valid || a_adv);
    assign load_a       = bus.in_valid && bus.in_ready;

    // A new instruction gets its own address; otherwise A's address is replayed so
    // cs_bits always belongs to whatever sits in A. Forced to zero during reset.
    assign bus.cs_addr = reset  ? '0 :
                         load_a ? caddr(bus.in_ir) : caddr(a_ir);

    assign bus.out_valid = b_valid && !bus.flush;
    assign bus.out_ir    = b_ir;
    assign bus.out_npc   = b_npc;
    assign bus.out_cs    = b_cs;

    // Slot update: A->B with the ROM word, input->A; flush empties both slots.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_valid <= 1'b0;
            a_ir    <= '0;
            a_npc   <= '0;
            b_valid <= 1'b0;
            b_ir    <= '0;
            b_npc   <= '0;
            b_cs    <= '0;
        end else if (bus.flush) begin
            a_valid <= 1'b0;
            b_valid <= 1'b0;
        end else begin
            if (a_adv) begin
                b_valid <= 1'b1;
                b_ir    <= a_ir;
                b_npc   <= a_npc;
                b_cs    <= bus.cs_bits;
            end else if (b_valid && bus.out_ready) begin
                b_valid <= 1'b0;
            end

            if (load_a) begin
                a_valid <= 1'b1;
                a_ir    <= bus.in_ir;
                a_npc   <= bus.in_npc;
            end else if (a_adv) begin
                a_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_decode_cs_stage.sv
// Bench for decode_cs_stage: table of instructions with hand-derived ROM addresses, scoreboard on the output side.
// Latency: checks the 2-cycle accept-to-output path and 1/cycle streaming.
// Backpressure: exercises stalls, toggling out_ready, flush and mid-stream reset.
module tb_decode_cs_stage;
    localparam int CS_W   = 23;
    localparam int ADDR_W = 6;

    typedef struct {
        logic [15:0]       ir;
        logic [15:0]       npc;
        logic [ADDR_W-1:0] exp_addr;
    } vec_t;

    typedef struct {
        logic [15:0]     ir;
        logic [15:0]     npc;
        logic [CS_W-1:0] cs;
    } exp_t;

    logic clk;
    logic reset;
    decode_cs_if #(.CS_W(CS_W), .ADDR_W(ADDR_W)) bus ();

    decode_cs_stage #(.CS_W(CS_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    vec_t vt [11];
    exp_t sb [$];

    int n_vec = 0;
    int n_err = 0;
    int n_out = 0;
    int stall_seen = 0;
    int rdy_mode = 0;           // 0: out_ready=1, 1: toggle each cycle, 3: driven by hand
    logic [ADDR_W-1:0] last_addr = '0;

    logic        hold = 1'b0;
    logic [15:0] h_ir, h_npc;
    logic [CS_W-1:0] h_cs;

    // Arbitrary but address-distinct ROM contents.
    function automatic logic [CS_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        return {a, a ^ 6'h2a, ~a, a[4:0] ^ 5'h15};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ControlStore model: synchronous read.
    always @(posedge clk) bus.cs_bits <= rom_word(bus.cs_addr);

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // out_ready pattern generator.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) bus.out_ready = ~bus.out_ready;
            else if (rdy_mode == 0) bus.out_ready = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output monitor: scoreboard pop on handshake, stability while stalled.
    always @(negedge clk) begin
        if (reset || bus.flush) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", 32'(bus.out_valid), 32'd1);
                chk("hold_ir", 32'(bus.out_ir), 32'(h_ir));
                chk("hold_npc", 32'(bus.out_npc), 32'(h_npc));
                chk("hold_cs", 32'(bus.out_cs), 32'(h_cs));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: got ir %h, expected no output", bus.out_ir);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_ir", 32'(bus.out_ir), 32'(e.ir));
                    chk("out_npc", 32'(bus.out_npc), 32'(e.npc));
                    chk("out_cs", 32'(bus.out_cs), 32'(e.cs));
                    n_out++;
                end
                hold = 1'b0;
            end else if (bus.out_valid) begin
                hold  = 1'b1;
                h_ir  = bus.out_ir;
                h_npc = bus.out_npc;
                h_cs  = bus.out_cs;
            end else begin
                hold = 1'b0;
            end
        end
    end

    // Present vt[idx] until accepted; returns 1 time unit after the accepting edge with in_valid still high.
    task automatic send(input int idx);
        int  waited = 0;
        bit  done = 0;
        bus.in_valid = 1'b1;
        bus.in_ir    = vt[idx].ir;
        bus.in_npc   = vt[idx].npc;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) begin
                chk("cs_addr_accept", 32'(bus.cs_addr), 32'(vt[idx].exp_addr));
                sb.push_back('{vt[idx].ir, vt[idx].npc, rom_word(vt[idx].exp_addr)});
                last_addr = vt[idx].exp_addr;
                done = 1;
            end else begin
                chk("cs_addr_replay", 32'(bus.cs_addr), 32'(last_addr));
                stall_seen++;
                waited++;
                if (waited > 60) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL accept_timeout: ir %h not accepted, required acceptance", vt[idx].ir);
                    done = 1;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string tag);
        int w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_drain: %0d outstanding, required 0", tag, sb.size());
        end
    endtask

    initial begin
        int n0;
        vt[0]  = '{16'h0000, 16'h3002, 6'd0};
        vt[1]  = '{16'h1261, 16'h3004, 6'd5};
        vt[2]  = '{16'h2820, 16'h3006, 6'd11};
        vt[3]  = '{16'h3020, 16'h3008, 6'd13};
        vt[4]  = '{16'h4800, 16'h300A, 6'd18};
        vt[5]  = '{16'h5800, 16'h300C, 6'd22};
        vt[6]  = '{16'h6FFF, 16'h300E, 6'd27};
        vt[7]  = '{16'h7800, 16'h3010, 6'd30};
        vt[8]  = '{16'hE005, 16'h3012, 6'd56};
        vt[9]  = '{16'hFFFF, 16'h3014, 6'd63};
        vt[10] = '{16'h0820, 16'h3016, 6'd3};

        bus.in_valid  = 1'b0;
        bus.in_ir     = '0;
        bus.in_npc    = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        reset         = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_cs_addr", 32'(bus.cs_addr), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("post_rst_out_cs", 32'(bus.out_cs), 32'd0);
        @(posedge clk);
        #1;

        // Single instruction: cs_addr=5 at accept, out_valid two cycles later.
        send(1);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t2_valid_t1", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t2_valid_t2", 32'(bus.out_valid), 32'd1);
        chk("t2_out_ir", 32'(bus.out_ir), 32'h1261);
        @(posedge clk);
        #1;
        drain("t2");

        // Stream opcodes 0..7 with a three-cycle AGEX stall.
        n0 = n_out;
        stall_seen = 0;
        rdy_mode = 3;
        bus.out_ready = 1'b1;
        fork
            begin
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join_none
        for (int i = 0; i < 8; i++) send(i);
        bus.in_valid = 1'b0;
        drain("t3");
        chk("t3_count", 32'(n_out - n0), 32'd8);
        chk("t3_in_ready_dropped", 32'(stall_seen > 0), 32'd1);
        rdy_mode = 0;

        // out_ready toggling with continuous input.
        n0 = n_out;
        rdy_mode = 1;
        for (int i = 0; i < 8; i++) send(i);
        bus.in_valid = 1'b0;
        drain("t5");
        rdy_mode = 0;
        chk("t5_count", 32'(n_out - n0), 32'd8);
        @(posedge clk);
        #1;

        // Both slots full, then a one-cycle flush.
        rdy_mode = 3;
        bus.out_ready = 1'b0;
        send(9);
        send(10);
        bus.in_valid = 1'b0;
        bus.flush = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("t4_flush_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t4_flush_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        @(negedge clk);
        chk("t4_after_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t4_after_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        rdy_mode = 0;
        bus.out_ready = 1'b1;
        n0 = n_out;
        send(8);
        bus.in_valid = 1'b0;
        drain("t4");
        chk("t4_count", 32'(n_out - n0), 32'd1);

        // Flush with in_valid high while B drains.
        send(2);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_ir    = vt[3].ir;
        bus.in_npc   = vt[3].npc;
        sb.delete();
        @(negedge clk);
        chk("t6_flush_in_ready", 32'(bus.in_ready), 32'd0);
        chk("t6_flush_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t6_next_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_next_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t6_a_empty", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Reset for two cycles mid-stream with A and B full and input pending.
        rdy_mode = 3;
        bus.out_ready = 1'b0;
        send(9);
        send(10);
        bus.in_ir  = vt[4].ir;
        bus.in_npc = vt[4].npc;
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("t1_rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("t1_rst_cs_addr", 32'(bus.cs_addr), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t1_rst2_cs_addr", 32'(bus.cs_addr), 32'd0);
        chk("t1_rst2_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.in_valid = 1'b0;
        rdy_mode = 0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t1_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t1_out_cs", 32'(bus.out_cs), 32'd0);
        chk("t1_out_ir", 32'(bus.out_ir), 32'd0);
        chk("t1_out_npc", 32'(bus.out_npc), 32'd0);
        chk("t1_cs_addr", 32'(bus.cs_addr), 32'd0);
        chk("t1_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        n0 = n_out;
        send(6);
        bus.in_valid = 1'b0;
        drain("t1");
        chk("t1_recover_count", 32'(n_out - n0), 32'd1);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
